// File: rtl/bcd_div_seq_pkg.sv
// Shared definitions for the calculator BCD divider slice.
// Provides the sequencer state type, BCD digit constants and a
// digit-range helper. No ports.
package calc_pkg;

  localparam int BCD_W  = 4;
  localparam int PART_W = 7;  // rem*10 + digit never exceeds 89

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SUB,
    DONE
  } state_e;

  function automatic logic digit_ok(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_div_seq_if.sv
// Handshake/data bundle between the operation controller and the BCD
// divider.
//   master: drives start, dividend, divisor; observes results.
//   slave : the divider; drives busy, done, quotient, remainder, div_err.
interface bcd_div_seq_if
  import calc_pkg::*;
#(
  parameter int NDIG = 4
);

  logic                    start;
  logic [BCD_W*NDIG-1:0]   dividend;
  logic [BCD_W-1:0]        divisor;
  logic                    busy;
  logic                    done;
  logic [BCD_W*NDIG-1:0]   quotient;
  logic [BCD_W-1:0]        remainder;
  logic                    div_err;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_err
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_err
  );

endinterface

// File: rtl/bcd_div_seq_mul10_add.sv
// Combinational partial-remainder builder: sum_o = rem_i*10 + digit_i.
//   rem_i   : running remainder digit (0..9)
//   digit_i : next dividend digit (0..9)
//   sum_o   : 7-bit partial (max 89)
module bcd_mul10_add
  import calc_pkg::*;
(
  input  logic [BCD_W-1:0]  rem_i,
  input  logic [BCD_W-1:0]  digit_i,
  output logic [PART_W-1:0] sum_o
);

  logic [PART_W-1:0] rem_x;
  logic [PART_W-1:0] dig_x;

  assign rem_x = {{(PART_W-BCD_W){1'b0}}, rem_i};
  assign dig_x = {{(PART_W-BCD_W){1'b0}}, digit_i};

  // x*10 = x*8 + x*2
  assign sum_o = (rem_x << 3) + (rem_x << 1) + dig_x;

endmodule

// File: rtl/bcd_div_seq.sv
// Sequential BCD long divider: NDIG-digit packed BCD dividend divided by
// one BCD digit, MSD first, one trial subtraction per clock.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of bcd_div_seq_if (start/busy/done handshake,
//                operands in, quotient/remainder/div_err out)
module bcd_div_seq
  import calc_pkg::*;
#(
  parameter int NDIG = 4
)
(
  input logic           clk,
  input logic           rst_n,
  bcd_div_seq_if.slave  bus
);

  localparam int DW = BCD_W * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e             state_q, state_d;
  logic [DW-1:0]      dvd_q, dvd_d;
  logic [DW-1:0]      qwork_q, qwork_d;
  logic [BCD_W-1:0]   dvs_q, dvs_d;
  logic [BCD_W-1:0]   rem_q, rem_d;
  logic [BCD_W-1:0]   qdig_q, qdig_d;
  logic [PART_W-1:0]  part_q, part_d;
  logic [IW-1:0]      idx_q, idx_d;

  logic [DW-1:0]      quot_q;
  logic [BCD_W-1:0]   remo_q;
  logic               div_err_q;

  logic               operands_ok;
  logic               load_res;
  logic               res_err;
  logic [BCD_W-1:0]   cur_digit;
  logic [PART_W-1:0]  load_val;
  logic [PART_W-1:0]  dvs_x;

  assign cur_digit = dvd_q[idx_q*BCD_W +: BCD_W];
  assign dvs_x     = {{(PART_W-BCD_W){1'b0}}, dvs_q};

  bcd_mul10_add u_mul10 (
    .rem_i   (rem_q),
    .digit_i (cur_digit),
    .sum_o   (load_val)
  );

  always_comb begin
    operands_ok = (bus.divisor != '0) && digit_ok(bus.divisor);
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (!digit_ok(bus.dividend[k*BCD_W +: BCD_W])) operands_ok = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    qdig_d   = qdig_q;
    part_d   = part_q;
    idx_d    = idx_q;
    qwork_d  = qwork_q;
    load_res = 1'b0;
    res_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          idx_d   = IW'(NDIG - 1);
          rem_d   = '0;
          qwork_d = '0;
          if (operands_ok) begin
            state_d = LOAD;
          end else begin
            // Bad operands skip straight to DONE so done follows next cycle.
            state_d  = DONE;
            load_res = 1'b1;
            res_err  = 1'b1;
          end
        end
      end
      LOAD: begin
        part_d  = load_val;
        qdig_d  = '0;
        state_d = SUB;
      end
      SUB: begin
        if (part_q >= dvs_x) begin
          part_d = part_q - dvs_x;
          qdig_d = qdig_q + 1'b1;
        end else begin
          qwork_d[idx_q*BCD_W +: BCD_W] = qdig_q;
          rem_d = part_q[BCD_W-1:0];
          if (idx_q == '0) begin
            state_d  = DONE;
            load_res = 1'b1;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = LOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      qdig_q    <= '0;
      part_q    <= '0;
      idx_q     <= '0;
      qwork_q   <= '0;
      quot_q    <= '0;
      remo_q    <= '0;
      div_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qdig_q  <= qdig_d;
      part_q  <= part_d;
      idx_q   <= idx_d;
      qwork_q <= qwork_d;
      // Results load on the edge entering DONE so they are valid with done.
      if (load_res) begin
        quot_q    <= res_err ? '0 : qwork_d;
        remo_q    <= res_err ? '0 : rem_d;
        div_err_q <= res_err;
      end
    end
  end

  assign bus.busy      = (state_q == LOAD) || (state_q == SUB);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = remo_q;
  assign bus.div_err   = div_err_q;

endmodule

// File: tb/tb_bcd_div_seq.sv
// Self-checking bench for bcd_div_seq (NDIG=4): arithmetic reference
// model checked every cycle plus directed vectors with literal results.
module tb_bcd_div_seq;

  localparam int NDIG = 4;

  logic clk;
  logic rst_n;

  bcd_div_seq_if #(.NDIG(NDIG)) bus ();

  bcd_div_seq #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer division of the decoded operands.
  function automatic void model(input logic [15:0] dvd, input logic [3:0] dvs,
                                output logic [15:0] q, output logic [3:0] r,
                                output logic e, output int lat);
    int n, qi, dg;
    bit bad;
    bad = (dvs == 0) || (dvs > 9);
    for (int i = 0; i < NDIG; i++) if (dvd[i*4 +: 4] > 9) bad = 1;
    q = '0; r = '0; e = bad; lat = 1;
    if (bad) return;
    n = 0;
    for (int i = NDIG - 1; i >= 0; i--) n = n * 10 + int'(dvd[i*4 +: 4]);
    qi = n / int'(dvs);
    r  = 4'(n % int'(dvs));
    for (int i = 0; i < NDIG; i++) begin
      dg = qi % 10;
      qi = qi / 10;
      q[i*4 +: 4] = 4'(dg);
      lat += dg + 2;
    end
  endfunction

  // Model timeline: m_k counts cycles since accept (0 = idle); done cycle is m_k==m_lat.
  int          m_k, m_lat;
  logic [15:0] p_q, e_q;
  logic [3:0]  p_r, e_r;
  logic        p_err, e_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_lat = 0; e_q = '0; e_r = '0; e_err = 1'b0;
    end else if (m_k == 0) begin
      if (bus.start) begin
        model(bus.dividend, bus.divisor, p_q, p_r, p_err, m_lat);
        m_k = 1;
        if (m_lat == 1) begin e_q = p_q; e_r = p_r; e_err = p_err; end
      end
    end else if (m_k == m_lat) begin
      m_k = 0;
    end else begin
      m_k++;
      if (m_k == m_lat) begin e_q = p_q; e_r = p_r; e_err = p_err; end
    end
  end

  always @(negedge clk) begin
    chk("cmp_busy", 32'(bus.busy), 32'((m_k != 0) && (m_k != m_lat)));
    chk("cmp_done", 32'(bus.done), 32'((m_k != 0) && (m_k == m_lat)));
    chk("cmp_quotient", 32'(bus.quotient), 32'(e_q));
    chk("cmp_remainder", 32'(bus.remainder), 32'(e_r));
    chk("cmp_div_err", 32'(bus.div_err), 32'(e_err));
  end

  // Called at the negedge of cycle k0 after accept; waits for done.
  task automatic wait_result(input int k0, input logic [15:0] eq, input logic [3:0] er,
                             input logic eerr, input int elat, input int ebusy, input int nb0);
    int k, nb;
    k = k0; nb = nb0;
    while (!bus.done && k < 300) begin
      if (bus.busy) nb++;
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
    chk("latency", 32'(k), 32'(elat));
    chk("busy_cycles", 32'(nb), 32'(ebusy));
    chk("quotient", 32'(bus.quotient), 32'(eq));
    chk("remainder", 32'(bus.remainder), 32'(er));
    chk("div_err", 32'(bus.div_err), 32'(eerr));
  endtask

  task automatic run_op(input logic [15:0] dvd, input logic [3:0] dvs, input logic [15:0] eq,
                        input logic [3:0] er, input logic eerr, input int elat, input int ebusy);
    @(negedge clk);
    bus.dividend = dvd; bus.divisor = dvs; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = 16'($urandom); bus.divisor = 4'($urandom);
    wait_result(1, eq, er, eerr, elat, ebusy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_div_err", 32'(bus.div_err), 32'd0);
    rst_n = 1'b1;

    run_op(16'h9876, 4'd7,   16'h1410, 4'd6, 1'b0, 15, 14);
    run_op(16'h1234, 4'd0,   16'h0000, 4'd0, 1'b1, 1, 0);
    run_op(16'h9999, 4'd1,   16'h9999, 4'd0, 1'b0, 45, 44);
    run_op(16'h1234, 4'hA,   16'h0000, 4'd0, 1'b1, 1, 0);
    run_op(16'h0000, 4'd9,   16'h0000, 4'd0, 1'b0, 9, 8);
    run_op(16'h12A4, 4'd3,   16'h0000, 4'd0, 1'b1, 1, 0);

    // start raised in the DONE cycle is ignored, held into first IDLE cycle is accepted
    bus.start = 1'b1; bus.dividend = 16'h0100; bus.divisor = 4'd3;
    @(negedge clk);
    chk("b2b_idle_busy", 32'(bus.busy), 32'd0);
    chk("b2b_idle_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    wait_result(1, 16'h0033, 4'd1, 1'b0, 15, 14, 0);

    // start pulse mid-operation must not disturb the running divide
    @(negedge clk);
    bus.dividend = 16'h9876; bus.divisor = 4'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.dividend = 16'h5555; bus.divisor = 4'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_result(5, 16'h1410, 4'd6, 1'b0, 15, 14, 4);

    // asynchronous reset while in SUB
    @(negedge clk);
    bus.dividend = 16'h9876; bus.divisor = 4'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_quotient", 32'(bus.quotient), 32'd0);
    chk("midrst_remainder", 32'(bus.remainder), 32'd0);
    chk("midrst_div_err", 32'(bus.div_err), 32'd0);
    repeat (2) @(negedge clk);
    chk("midrst_no_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    run_op(16'h0042, 4'd6, 16'h0007, 4'd0, 1'b0, 16, 15);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
